i3c_fifo_word_port: RTL

I3C_FIFO_WORD_PORT -- requirements
Module: i3c_fifo_word_port

---
 rtl/i3c_params.sv | 29 ++
 rtl/i3c_fifo_word_port_if.sv | 47 ++++
 rtl/i3c_fb_word_packer.sv | 102 ++++++++++
 rtl/i3c_fifo_word_port.sv | 114 +++++++++++
 4 files changed

// File: rtl/i3c_params.sv
// Shared constants and state encodings for the I3C FIFO word port.
// Ports: none (package only).
// Holds the TX/RX FSM encodings, the lane-count width and a byte-select helper.
package i3c_params;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_HOLD    = 1'b1
  } rx_state_e;

  // Lane count runs 0..4, so it needs one bit more than a byte index.
  localparam int                    LANE_CNT_W     = 3;
  localparam logic [LANE_CNT_W-1:0] LANES_PER_WORD = 3'd4;
  localparam logic [LANE_CNT_W-1:0] LAST_LANE      = 3'd3;

  // Wide enough for the largest legal RX_TIMEOUT (255).
  localparam int TCNT_W = 8;

  // Byte k of a 32-bit word, little-endian lane order.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/i3c_fifo_word_port_if.sv
// Host-word / byte-FIFO bundle for the I3C FIFO word port.
// Ports: TX word side, to-bus byte push, RX word side, from-bus byte pop, flush requests/pulses.
// slave = the word port itself; master = the host plus the two byte FIFOs.
interface i3c_fifo_word_port_if;
  import i3c_params::*;

  logic                  tx_valid;
  logic [31:0]           tx_data;
  logic [1:0]            tx_nbytes;
  logic                  tx_last;
  logic                  tx_ready;

  logic                  avail_tb_ready;
  logic [7:0]            avail_tb_data;
  logic                  avail_tb_end;
  logic                  avail_tb_full;

  logic                  tx_flush;
  logic                  tb_flush;

  logic                  rx_valid;
  logic [31:0]           rx_data;
  logic [LANE_CNT_W-1:0] rx_nbytes;
  logic                  rx_ready;

  logic                  notify_fb_ready;
  logic [7:0]            notify_fb_data;
  logic                  notify_fb_ack;

  logic                  rx_flush;
  logic                  fb_flush;

  modport slave (
    input  tx_valid, tx_data, tx_nbytes, tx_last, avail_tb_full, tx_flush,
           rx_ready, notify_fb_ready, notify_fb_data, rx_flush,
    output tx_ready, avail_tb_ready, avail_tb_data, avail_tb_end, tb_flush,
           rx_valid, rx_data, rx_nbytes, notify_fb_ack, fb_flush
  );

  modport master (
    output tx_valid, tx_data, tx_nbytes, tx_last, avail_tb_full, tx_flush,
           rx_ready, notify_fb_ready, notify_fb_data, rx_flush,
    input  tx_ready, avail_tb_ready, avail_tb_data, avail_tb_end, tb_flush,
           rx_valid, rx_data, rx_nbytes, notify_fb_ack, fb_flush
  );

endinterface

// File: rtl/i3c_fb_word_packer.sv
// Packs bytes popped from the from-bus FIFO into host RX words of 1..4 bytes.
// Ports: i_clk/i_rst, byte pop (i_fb_ready/i_fb_data/o_fb_ack), word out (o_rx_*/i_rx_ready), flush in/pulse out.
// A partial word is released after RX_TIMEOUT idle cycles; no byte is acked while a word is held.
module i3c_fb_word_packer
  import i3c_params::*;
#(
  parameter int RX_TIMEOUT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fb_ready,
  input  logic [7:0]            i_fb_data,
  output logic                  o_fb_ack,
  input  logic                  i_rx_flush,
  output logic                  o_fb_flush,
  output logic                  o_rx_valid,
  output logic [31:0]           o_rx_data,
  output logic [LANE_CNT_W-1:0] o_rx_nbytes,
  input  logic                  i_rx_ready
);

  localparam logic [TCNT_W-1:0] TIMEOUT = TCNT_W'(RX_TIMEOUT);

  rx_state_e             r_state;
  rx_state_e             w_next;
  logic [LANE_CNT_W-1:0] r_cnt;
  logic [TCNT_W-1:0]     r_tcnt;
  logic [31:0]           r_lanes;
  logic                  r_fb_flush;

  logic                  w_ack;
  logic                  w_release;
  logic                  w_idle_tick;
  logic                  w_timeout;
  logic [TCNT_W-1:0]     w_tcnt_inc;

  // Flush and reset both suppress the ack in the same cycle so no byte is lost into a cleared word.
  assign w_ack       = !i_rst && !i_rx_flush && (r_state == RX_COLLECT) &&
                       (r_cnt < LANES_PER_WORD) && i_fb_ready;
  assign w_release   = !i_rst && !i_rx_flush && (r_state == RX_HOLD) && i_rx_ready;
  // The idle timer only runs once at least one lane holds data, so an empty word never escapes.
  assign w_idle_tick = (r_state == RX_COLLECT) && !w_ack && (r_cnt != '0);
  assign w_tcnt_inc  = r_tcnt + TCNT_W'(1);
  assign w_timeout   = w_idle_tick && (w_tcnt_inc >= TIMEOUT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RX_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_rx_flush) begin
      w_next = RX_COLLECT;
    end else begin
      case (r_state)
        RX_COLLECT: if ((w_ack && (r_cnt == LAST_LANE)) || w_timeout) w_next = RX_HOLD;
        RX_HOLD:    if (i_rx_ready) w_next = RX_COLLECT;
        default:    w_next = RX_COLLECT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_tcnt     <= '0;
      r_lanes    <= '0;
      r_fb_flush <= 1'b0;
    end else begin
      r_fb_flush <= i_rx_flush;
      if (i_rx_flush || w_release) begin
        r_cnt   <= '0;
        r_tcnt  <= '0;
        r_lanes <= '0;
      end else if (w_ack) begin
        r_lanes[{r_cnt[1:0], 3'b000} +: 8] <= i_fb_data;
        r_cnt  <= r_cnt + LANE_CNT_W'(1);
        r_tcnt <= '0;
      end else if (w_idle_tick) begin
        r_tcnt <= w_tcnt_inc;
      end
    end
  end

  always_comb begin
    o_fb_ack    = w_ack;
    o_fb_flush  = r_fb_flush && !i_rst;
    o_rx_valid  = 1'b0;
    o_rx_data   = '0;
    o_rx_nbytes = '0;
    if (!i_rst && (r_state == RX_HOLD)) begin
      o_rx_valid  = 1'b1;
      o_rx_data   = r_lanes;
      o_rx_nbytes = r_cnt;
    end
  end

endmodule

// File: rtl/i3c_fifo_word_port.sv
// Host word port for an I3C controller: splits TX words into to-bus bytes, packs from-bus bytes into RX words.
// Ports: CLK/RST, bus (i3c_fifo_word_port_if.slave) carrying both word sides and both byte-FIFO sides.
// TX pushes one byte per cycle, holding while avail_tb_full; RX path lives in i3c_fb_word_packer.
module i3c_fifo_word_port
  import i3c_params::*;
#(
  parameter int RX_TIMEOUT = 8
) (
  input logic                 CLK,
  input logic                 RST,
  i3c_fifo_word_port_if.slave bus
);

  tx_state_e   r_tx_state;
  tx_state_e   w_tx_next;
  logic [31:0] r_tx_word;
  logic [1:0]  r_tx_nbytes;
  logic        r_tx_last;
  logic [1:0]  r_idx;
  logic        r_tb_flush;

  logic        w_push;
  logic        w_last_byte;

  // A byte leaves whenever it is offered and the FIFO is not full; the FIFO ack is not needed.
  assign w_push      = (r_tx_state == TX_SEND) && !bus.avail_tb_full;
  assign w_last_byte = (r_idx == r_tx_nbytes);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    if (bus.tx_flush) begin
      w_tx_next = TX_IDLE;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (bus.tx_valid) w_tx_next = TX_SEND;
        TX_SEND: if (w_push && w_last_byte) w_tx_next = TX_IDLE;
        default: w_tx_next = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tx_word   <= '0;
      r_tx_nbytes <= '0;
      r_tx_last   <= 1'b0;
      r_idx       <= '0;
      r_tb_flush  <= 1'b0;
    end else begin
      r_tb_flush <= bus.tx_flush;
      if (bus.tx_flush) begin
        r_idx <= '0;
      end else if ((r_tx_state == TX_IDLE) && bus.tx_valid) begin
        r_tx_word   <= bus.tx_data;
        r_tx_nbytes <= bus.tx_nbytes;
        r_tx_last   <= bus.tx_last;
        r_idx       <= '0;
      end else if (w_push) begin
        r_idx <= w_last_byte ? 2'd0 : r_idx + 2'd1;
      end
    end
  end

  // Outputs are forced to their idle values while RST is high, not just after the reset edge.
  always_comb begin
    bus.tx_ready       = RST || (r_tx_state == TX_IDLE);
    bus.avail_tb_ready = 1'b0;
    bus.avail_tb_data  = '0;
    bus.avail_tb_end   = 1'b0;
    bus.tb_flush       = r_tb_flush && !RST;
    if (!RST && (r_tx_state == TX_SEND)) begin
      bus.avail_tb_ready = 1'b1;
      bus.avail_tb_data  = word_byte(r_tx_word, r_idx);
      bus.avail_tb_end   = w_last_byte && r_tx_last;
    end
  end

  logic                  w_fb_ack;
  logic                  w_fb_flush;
  logic                  w_rx_valid;
  logic [31:0]           w_rx_data;
  logic [LANE_CNT_W-1:0] w_rx_nbytes;

  i3c_fb_word_packer #(
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_packer (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_fb_ready  (bus.notify_fb_ready),
    .i_fb_data   (bus.notify_fb_data),
    .o_fb_ack    (w_fb_ack),
    .i_rx_flush  (bus.rx_flush),
    .o_fb_flush  (w_fb_flush),
    .o_rx_valid  (w_rx_valid),
    .o_rx_data   (w_rx_data),
    .o_rx_nbytes (w_rx_nbytes),
    .i_rx_ready  (bus.rx_ready)
  );

  assign bus.notify_fb_ack = w_fb_ack;
  assign bus.fb_flush      = w_fb_flush;
  assign bus.rx_valid      = w_rx_valid;
  assign bus.rx_data       = w_rx_data;
  assign bus.rx_nbytes     = w_rx_nbytes;

endmodule
